imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

Registered immediate-generation stage between instruction fetch/decode and the datapath operand path (upper-immediate, extension and branch-offset units). It accepts a 32-bit MIPS instruction over a valid/ready handshake and classifies the opcode. It emits the fully formed 32-bit immediate, the destination register field and an immediate-kind tag. A 2-entry buffer absorbs downstream back-pressure without bubbles, and a saturating counter tracks unrecognised opcodes.

## Interface
- No parameters; all widths fixed.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_instr  input  32  instruction word; opcode [31:26], rt [20:16], imm16 [15:0]
- in_valid  input  1  in_instr valid this cycle
- in_ready  output  1  stage can accept; equals (count != 2), derived only from registered state
- out_imm  output  32  generated immediate of head entry
- out_rt  output  5  rt field of head entry
- out_kind  output  3  0 NONE, 1 ZEXT, 2 SEXT, 3 LUI, 4 BR
- out_valid  output  1  head entry valid (count != 0)
- out_ready  input  1  consumer takes head entry this cycle
- unk_cnt  output  8  saturating count of accepted unrecognised opcodes

## Operation
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Opcode classification, decoded at accept time and stored in the entry:
  - 0x0F LUI: imm = {imm16, 16'h0000}, kind 3.
  - 0x0C/0x0D/0x0E (ANDI/ORI/XORI): imm = {16'h0000, imm16}, kind 1.
  - 0x08/0x09/0x0A/0x0B/0x23/0x2B (ADDI/ADDIU/SLTI/SLTIU/LW/SW): imm = {{16{imm16[15]}}, imm16}, kind 2.
  - 0x04/0x05 (BEQ/BNE): imm = {{14{imm16[15]}}, imm16, 2'b00}, kind 4.
  - 0x00 (R-type) and 0x02/0x03 (J/JAL): imm = 0, kind 0. These are recognised and do not count.
  - Any other opcode: imm = 0, kind 0, and unk_cnt increments by 1, saturating at 255.
- out_rt = in_instr[20:16] for every kind, including NONE.
- Buffer: 2-entry FIFO, head is entry 0, count ∈ {0,1,2}. Strict in-order delivery.
- Head outputs are driven directly from registers. No combinational path runs from in_instr to the out_* signals.
- State transitions by (accept, pop):
  - (1,0): count+1.
  - (0,1): count−1; entry 1 shifts to head.
  - (1,1) with count=1: new entry replaces head; count stays 1.
  - (1,1) with count=2: not possible, because in_ready=0.
  - (0,0): hold.
- While out_valid=1 and out_ready=0, out_imm, out_rt and out_kind stay stable.
- When count=0, the out_imm, out_rt and out_kind values are don't-care but remain at their last value (0 after reset).

## Timing
- Latency: an instruction accepted in cycle N appears at the head in cycle N+1 if count was 0 or became 0 by a pop in cycle N.
- Throughput: 1 instruction/cycle while out_ready=1.
- in_ready: low only when count=2. It rises the cycle after a pop from full.
- Reset (asynchronous, any time, including mid-transfer):
  - count=0, out_valid=0, in_ready=1.
  - out_imm=0, out_rt=0, out_kind=0, unk_cnt=0.
  - Buffered entries are discarded.
- First accept is possible on the first rising edge with rst_n=1.
- unk_cnt updates on the edge where the unrecognised instruction is accepted, independent of pop.

## Test plan
- LUI/ORI: accept 0x3C01ABCD then 0x34228001 with out_ready=1. Required:
  - Cycle N+1: imm 0xABCD0000, rt 1, kind 3.
  - Cycle N+2: imm 0x00008001, rt 2, kind 1.
- ADDI/BEQ: accept 0x2003FFFC then 0x1000FFFF. Required:
  - imm 0xFFFFFFFC, rt 3, kind 2.
  - imm 0xFFFFFFFC, rt 0, kind 4.
  - Repeat with imm16=0x0001: results 0x00000001 and 0x00000004.
- Back-pressure: out_ready=0, drive 3 back-to-back valid instructions A, B, C. Required:
  - A and B accepted; in_ready=0 after B; head holds A stable.
  - Raise out_ready: outputs A, B, C in order.
  - No loss or duplication; C accepted the cycle after in_ready rises.
- Simultaneous accept+pop at count=1 for 10 cycles with a streaming sequence: one output per cycle, count stays 1, order preserved.
- Unknown opcode: send 260 instructions with opcode 0x3F, then one 0x00 R-type. Required:
  - Every output has kind 0 and imm 0.
  - unk_cnt saturates at 255 and stays 255 after the R-type.
- Reset mid-operation: count=2 and unk_cnt=5; pulse rst_n low asynchronously between clock edges. Required:
  - Immediately: out_valid=0, in_ready=1, unk_cnt=0, out_imm=0.
  - After release, the next accepted instruction appears alone, with no stale entries.

Source files
------------

// File: rtl/imm_gen_stage.sv
// Registered MIPS immediate-generation stage: decodes the opcode at accept time,
// buffers up to two results and counts unrecognised opcodes (saturating).
module imm_gen_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rt,
  output logic [2:0]  out_kind,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  unk_cnt
);

  typedef enum logic [2:0] {
    KIND_NONE = 3'd0,
    KIND_ZEXT = 3'd1,
    KIND_SEXT = 3'd2,
    KIND_LUI  = 3'd3,
    KIND_BR   = 3'd4
  } kind_t;

  logic [1:0]  r_count;
  logic [31:0] r_imm0, r_imm1;
  logic [4:0]  r_rt0, r_rt1;
  kind_t       r_kind0, r_kind1;
  logic [7:0]  r_unk;

  logic        w_accept;
  logic        w_pop;
  logic [5:0]  w_opcode;
  logic [15:0] w_imm16;
  logic [4:0]  w_rt;
  logic [31:0] w_imm;
  kind_t       w_kind;
  logic        w_unk;
  logic        w_unused_bits;

  assign w_opcode      = in_instr[31:26];
  assign w_rt          = in_instr[20:16];
  assign w_imm16       = in_instr[15:0];
  assign w_unused_bits = ^in_instr[25:21];

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_accept  = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_comb begin
    w_imm  = 32'h0000_0000;
    w_kind = KIND_NONE;
    w_unk  = 1'b0;
    case (w_opcode)
      6'h0F: begin
        w_imm  = {w_imm16, 16'h0000};
        w_kind = KIND_LUI;
      end
      6'h0C, 6'h0D, 6'h0E: begin
        w_imm  = {16'h0000, w_imm16};
        w_kind = KIND_ZEXT;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
        w_imm  = {{16{w_imm16[15]}}, w_imm16};
        w_kind = KIND_SEXT;
      end
      6'h04, 6'h05: begin
        w_imm  = {{14{w_imm16[15]}}, w_imm16, 2'b00};
        w_kind = KIND_BR;
      end
      6'h00, 6'h02, 6'h03: begin
        w_kind = KIND_NONE;
      end
      default: begin
        w_unk = 1'b1;
      end
    endcase
  end

  // Head only shifts when a second entry exists, so an emptied head keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_imm0  <= 32'h0000_0000;
      r_imm1  <= 32'h0000_0000;
      r_rt0   <= 5'd0;
      r_rt1   <= 5'd0;
      r_kind0 <= KIND_NONE;
      r_kind1 <= KIND_NONE;
    end else begin
      case ({w_accept, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_imm0  <= w_imm;
            r_rt0   <= w_rt;
            r_kind0 <= w_kind;
          end else begin
            r_imm1  <= w_imm;
            r_rt1   <= w_rt;
            r_kind1 <= w_kind;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) begin
            r_imm0  <= r_imm1;
            r_rt0   <= r_rt1;
            r_kind0 <= r_kind1;
          end
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          r_imm0  <= w_imm;
          r_rt0   <= w_rt;
          r_kind0 <= w_kind;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_unk <= 8'd0;
    end else if (w_accept && w_unk && (r_unk != 8'hFF)) begin
      r_unk <= r_unk + 8'd1;
    end
  end

  assign out_imm  = r_imm0;
  assign out_rt   = r_rt0;
  assign out_kind = r_kind0;
  assign unk_cnt  = r_unk;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: driver pushes reference results into a
// queue, a monitor pops and compares whatever the stage presents.
module tb_imm_gen_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_imm;
  logic [4:0]  out_rt;
  logic [2:0]  out_kind;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  unk_cnt;

  typedef struct {
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [2:0]  kind;
    bit          unk;
  } exp_t;

  exp_t expQ[$];
  int   pendingAccept = 0;
  bit   checkEn = 0;
  int   mdlUnk = 0;
  int   total = 0;
  int   bad = 0;

  imm_gen_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_instr  (in_instr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_imm   (out_imm),
    .out_rt    (out_rt),
    .out_kind  (out_kind),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .unk_cnt   (unk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: immediate computed from the instruction's arithmetic meaning.
  function automatic exp_t refModel(input logic [31:0] instr);
    exp_t e;
    int   opc;
    int   u16;
    int   s16;
    opc = int'(instr[31:26]);
    u16 = int'(instr[15:0]);
    s16 = (u16 >= 32768) ? (u16 - 65536) : u16;
    e.rt   = instr[20:16];
    e.imm  = 32'h0;
    e.kind = 3'd0;
    e.unk  = 1'b0;
    if (opc == 15) begin
      e.imm = 32'(u16 * 65536); e.kind = 3'd3;
    end else if (opc >= 12 && opc <= 14) begin
      e.imm = 32'(u16); e.kind = 3'd1;
    end else if ((opc >= 8 && opc <= 11) || opc == 35 || opc == 43) begin
      e.imm = 32'(s16); e.kind = 3'd2;
    end else if (opc == 4 || opc == 5) begin
      e.imm = 32'(s16 * 4); e.kind = 3'd4;
    end else if (opc == 0 || opc == 2 || opc == 3) begin
      e.kind = 3'd0;
    end else begin
      e.unk = 1'b1;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Called at a negedge; holds the word until accepted and returns at the following negedge.
  task automatic applyStimulus(input logic [31:0] instr, input bit forceReady);
    int   waitCycles;
    exp_t e;
    waitCycles = 0;
    in_valid = 1'b1;
    in_instr = instr;
    pendingAccept = 0;
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
      if (forceReady && waitCycles > 2) out_ready = 1'b1;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      e = refModel(instr);
      expQ.push_back(e);
      if (e.unk && mdlUnk < 255) mdlUnk++;
      pendingAccept = 1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    pendingAccept = 0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    out_ready = 1'b1;
    while (expQ.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
    checkOutput("unk_cnt", 32'(unk_cnt), 32'(mdlUnk));
  endtask

  // Monitor: at each negedge+1 compare flags against model occupancy and the head against the queue.
  always begin
    int   cnt;
    exp_t e;
    @(negedge clk);
    #1;
    if (checkEn) begin
      cnt = expQ.size() - pendingAccept;
      checkOutput("out_valid", 32'(out_valid), 32'(cnt != 0));
      checkOutput("in_ready", 32'(in_ready), 32'(cnt != 2));
      if (out_valid && cnt > 0) begin
        e = expQ[0];
        checkOutput("out_imm", out_imm, e.imm);
        checkOutput("out_rt", 32'(out_rt), 32'(e.rt));
        checkOutput("out_kind", 32'(out_kind), 32'(e.kind));
        if (out_ready) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [5:0] opcPool [0:17];

  initial begin
    logic [31:0] w;
    opcPool = '{6'h0F, 6'h0C, 6'h0D, 6'h0E, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23,
                6'h2B, 6'h04, 6'h05, 6'h00, 6'h02, 6'h03, 6'h3F, 6'h01, 6'h1C};
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_instr = 32'h0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_imm", out_imm, 32'd0);
    checkOutput("rst_out_rt", 32'(out_rt), 32'd0);
    checkOutput("rst_out_kind", 32'(out_kind), 32'd0);
    checkOutput("rst_unk_cnt", 32'(unk_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkEn = 1'b1;

    $display("[TB] directed LUI/ORI/ADDI/BEQ");
    out_ready = 1'b1;
    applyStimulus(32'h3C01ABCD, 1'b1);
    applyStimulus(32'h34228001, 1'b1);
    applyStimulus(32'h2003FFFC, 1'b1);
    applyStimulus(32'h1000FFFF, 1'b1);
    applyStimulus(32'h20030001, 1'b1);
    applyStimulus(32'h10000001, 1'b1);
    drain();

    $display("[TB] back-pressure");
    out_ready = 1'b0;
    applyStimulus(32'h3C0A1111, 1'b0);
    applyStimulus(32'h340B2222, 1'b0);
    fork
      applyStimulus(32'h8C0C3333, 1'b0);
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] streaming at count=1");
    out_ready = 1'b0;
    applyStimulus(32'h24050010, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w = {opcPool[i % 12], 5'd0, 5'(i), 16'($urandom)};
      applyStimulus(w, 1'b1);
    end
    drain();

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 3; i++) applyStimulus({6'h3F, 26'($urandom)}, 1'b1);
    drain();
    out_ready = 1'b0;
    applyStimulus({6'h3F, 26'($urandom)}, 1'b0);
    applyStimulus({6'h3F, 26'($urandom)}, 1'b0);
    checkOutput("pre_rst_unk", 32'(unk_cnt), 32'd5);
    checkOutput("pre_rst_full", 32'(in_ready), 32'd0);
    checkEn = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("arst_unk_cnt", 32'(unk_cnt), 32'd0);
    checkOutput("arst_out_imm", out_imm, 32'd0);
    expQ.delete();
    mdlUnk = 0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkEn = 1'b1;
    out_ready = 1'b1;
    applyStimulus(32'h3C0F5A5A, 1'b1);
    drain();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 7) begin
        w = {opcPool[$urandom_range(0, 17)], 26'($urandom)};
        applyStimulus(w, 1'b1);
      end else begin
        @(negedge clk);
      end
    end
    drain();

    $display("[TB] unknown opcode saturation");
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) applyStimulus({6'h3F, 26'($urandom)}, 1'b1);
    applyStimulus({6'h00, 26'($urandom)}, 1'b1);
    drain();
    checkOutput("unk_saturated", 32'(unk_cnt), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
